commut_reg_bank: RTL and testbench

Parametrised, single-clock register bank for the 5-to-3 commutator. Each of CHANNELS output slots captures one WIDTH-bit word from any of SOURCES input lanes. Slots are loaded either by per-channel manual load enables or by a built-in auto-scan sequencer, which loads every slot in turn and rotates the source assignment after each scan. It replaces the fixed three-slot, per-slot-clocked register bank and feeds the commutator output stage.

---
 rtl/commut_pkg.sv | 29 ++
 rtl/commut_slot.sv | 37 +++
 rtl/commut_reg_bank.sv | 146 ++++++++++++++
 tb/tb_commut_reg_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/commut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commut_pkg
// Description : Shared defaults, sequencer state type and modular-add helper
//               for the commutator register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package commut_pkg;

    localparam int c_WIDTH_DEFAULT    = 3;
    localparam int c_CHANNELS_DEFAULT = 3;
    localparam int c_SOURCES_DEFAULT  = 5;

    // Auto-scan sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // (a + b) mod m; callers truncate the result to their own index width
    function automatic int unsigned mod_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned m);
        return (a + b) % m;
    endfunction

endpackage : commut_pkg
`default_nettype wire

// File: rtl/commut_slot.sv
`default_nettype none
// ============================================================================
// Module      : commut_slot
// Description : One output slot: a WIDTH-bit data register plus a sticky
//               "loaded since reset" flag.
// Revision    : 1.0 - initial release
// ============================================================================
module commut_slot #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Capture the word on a load; the valid flag stays set until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : commut_slot
`default_nettype wire

// File: rtl/commut_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : commut_reg_bank
// Description : CHANNELS-slot register bank fed from SOURCES lanes, loaded by
//               per-slot manual enables or by a rotating auto-scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module commut_reg_bank
    import commut_pkg::*;
#(
    parameter int WIDTH    = c_WIDTH_DEFAULT,
    parameter int CHANNELS = c_CHANNELS_DEFAULT,
    parameter int SOURCES  = c_SOURCES_DEFAULT,
    parameter int SEL_W    = $clog2(SOURCES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SOURCES*WIDTH-1:0]  src_data,
    input  logic [CHANNELS-1:0]       load_en,
    input  logic [CHANNELS*SEL_W-1:0] load_sel,
    input  logic                      mode,
    input  logic                      scan_start,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      scan_busy,
    output logic                      scan_done,
    output logic                      sel_err
);

    localparam int                 c_IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(CHANNELS - 1);
    // One extra bit so the range check also works when SOURCES == 2**SEL_W
    localparam logic [SEL_W:0]     c_SRC_LIMIT = (SEL_W + 1)'(SOURCES);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [SEL_W-1:0]    r_base;
    logic [SEL_W-1:0]    w_base_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic                r_sel_err;
    logic                w_scan_go;
    logic                w_manual_ok;
    logic [SEL_W-1:0]    w_scan_src;
    logic [CHANNELS-1:0] w_sel_bad;

    // Select lane 'sel' from the packed source bus; out-of-range gives zero
    function automatic logic [WIDTH-1:0] lane_pick(input logic [SOURCES*WIDTH-1:0] bus,
                                                   input logic [SEL_W-1:0]         sel);
        logic [WIDTH-1:0] w_pick;
        w_pick = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (sel == SEL_W'(i)) begin
                w_pick = bus[i*WIDTH +: WIDTH];
            end
        end
        return w_pick;
    endfunction

    // A scan start is only honoured from IDLE with auto mode; it wins over
    // any manual request in the same cycle.
    assign w_scan_go   = (r_state == IDLE) && mode && scan_start;
    assign w_manual_ok = (r_state == IDLE) && !w_scan_go;
    assign w_scan_src  = SEL_W'(mod_add(32'(r_base), 32'(r_idx), SOURCES));

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
            logic [SEL_W-1:0] w_sel;
            logic             w_in_range;
            logic             w_man_ld;
            logic             w_scan_ld;
            logic [WIDTH-1:0] w_data;

            assign w_sel      = load_sel[k*SEL_W +: SEL_W];
            assign w_in_range = ({1'b0, w_sel} < c_SRC_LIMIT);
            assign w_man_ld   = w_manual_ok && load_en[k] && w_in_range;
            assign w_scan_ld  = (r_state == SCAN) && (r_idx == c_IDX_W'(k));
            assign w_sel_bad[k] = w_manual_ok && load_en[k] && !w_in_range;
            assign w_data     = w_scan_ld ? lane_pick(src_data, w_scan_src)
                                          : lane_pick(src_data, w_sel);

            commut_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_man_ld || w_scan_ld),
                .i_data  (w_data),
                .o_data  (out[k*WIDTH +: WIDTH]),
                .o_valid (out_valid[k])
            );
        end
    endgenerate

    // Sequencer next-state: walk idx across the slots, then rotate base
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        case (r_state)
            IDLE: begin
                if (w_scan_go) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = DONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = c_IDX_W'(mod_add(32'(r_idx), 32'd1, CHANNELS));
                end
            end
            DONE: begin
                w_base_nxt  = SEL_W'(mod_add(32'(r_base), 32'd1, SOURCES));
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Sequencer, counters and the sticky select-error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_base    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_base    <= w_base_nxt;
            r_sel_err <= r_sel_err || (|w_sel_bad);
        end
    end

    assign scan_busy = (r_state == SCAN);
    assign scan_done = (r_state == DONE);
    assign sel_err   = r_sel_err;

endmodule : commut_reg_bank
`default_nettype wire

// File: tb/tb_commut_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_commut_reg_bank
// Description : Scoreboard bench for commut_reg_bank with default parameters
//               and lanes src0..src4 = 1..5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commut_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [14:0] src_data;
    logic [2:0] load_en;
    logic [8:0] load_sel;
    logic       mode;
    logic       scan_start;
    logic [8:0] out;
    logic [2:0] out_valid;
    logic       scan_busy;
    logic       scan_done;
    logic       sel_err;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         tag;
        string      name;
        logic [8:0] o;
        logic [2:0] v;
        logic       b;
        logic       d;
        logic       e;
    } exp_t;

    exp_t sb[$];

    commut_reg_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .mode       (mode),
        .scan_start (scan_start),
        .out        (out),
        .out_valid  (out_valid),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] pk(input logic [2:0] s0, input logic [2:0] s1,
                                      input logic [2:0] s2);
        return {s2, s1, s0};
    endfunction

    // Queue an expectation for the state seen after edge (cyc + dt)
    task automatic exp_at(input int dt, input string nm, input logic [8:0] o,
                          input logic [2:0] v, input logic b, input logic d,
                          input logic e);
        exp_t x;
        x.tag = cyc + dt; x.name = nm; x.o = o; x.v = v; x.b = b; x.d = d; x.e = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle, mid-cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag <= cyc) begin
                n_cmp++;
                if (sb[i].tag < cyc ||
                    out !== sb[i].o || out_valid !== sb[i].v ||
                    scan_busy !== sb[i].b || scan_done !== sb[i].d ||
                    sel_err !== sb[i].e) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got out=%h vld=%b busy=%b done=%b err=%b, want out=%h vld=%b busy=%b done=%b err=%b",
                             sb[i].name, cyc, out, out_valid, scan_busy, scan_done, sel_err,
                             sb[i].o, sb[i].v, sb[i].b, sb[i].d, sb[i].e);
                end
                sb.delete(i);
            end
        end
    end

    // One full scan: prev slot contents/valids in, loaded values expected
    task automatic do_scan(input string nm,
                           input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                           input logic [2:0] pv,
                           input logic [2:0] n0, input logic [2:0] n1, input logic [2:0] n2,
                           input logic hold_start, input logic drop_mode);
        scan_start = 1'b1;
        if (hold_start) begin
            load_en  = 3'b111;
            load_sel = '0;
        end
        exp_at(1, {nm, "_busy"}, pk(p0, p1, p2), pv,          1'b1, 1'b0, 1'b0);
        exp_at(2, {nm, "_s0"},   pk(n0, p1, p2), pv | 3'b001, 1'b1, 1'b0, 1'b0);
        exp_at(3, {nm, "_s1"},   pk(n0, n1, p2), pv | 3'b011, 1'b1, 1'b0, 1'b0);
        exp_at(4, {nm, "_done"}, pk(n0, n1, n2), 3'b111,      1'b0, 1'b1, 1'b0);
        exp_at(5, {nm, "_idle"}, pk(n0, n1, n2), 3'b111,      1'b0, 1'b0, 1'b0);
        exp_at(6, {nm, "_rest"}, pk(n0, n1, n2), 3'b111,      1'b0, 1'b0, 1'b0);
        tick();
        if (!hold_start) scan_start = 1'b0;
        if (drop_mode)   mode = 1'b0;
        repeat (4) tick();
        scan_start = 1'b0;
        load_en    = '0;
        mode       = 1'b1;
        tick();
    endtask

    initial begin
        src_data   = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        rst_n      = 1'b0;
        load_en    = '0;
        load_sel   = '0;
        mode       = 1'b0;
        scan_start = 1'b0;

        // Power-on reset
        exp_at(2, "reset_init", 9'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;

        // Manual load: slot0 <- lane3, slot2 <- lane1
        load_en  = 3'b101;
        load_sel = {3'd1, 3'd0, 3'd3};
        exp_at(1, "manual", pk(3'd4, 3'd0, 3'd2), 3'b101, 1'b0, 1'b0, 1'b0);
        tick();

        // Out-of-range select on slot1
        load_en  = 3'b010;
        load_sel = {3'd0, 3'd6, 3'd0};
        exp_at(1, "bad_sel", pk(3'd4, 3'd0, 3'd2), 3'b101, 1'b0, 1'b0, 1'b1);
        tick();

        // A valid load afterwards leaves the error flag set
        load_sel = {3'd0, 3'd4, 3'd0};
        exp_at(1, "err_sticky", pk(3'd4, 3'd5, 3'd2), 3'b111, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset for two cycles with manual traffic present
        rst_n    = 1'b0;
        load_en  = 3'b111;
        load_sel = '0;
        exp_at(1, "reset_ovr", 9'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        exp_at(2, "reset_mid", 9'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n   = 1'b1;
        load_en = '0;
        mode    = 1'b1;

        // Scan 1, base 0
        do_scan("scan1", 3'd0, 3'd0, 3'd0, 3'b000, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);

        // Reset at the edge where slot1 would load (base 1 scan)
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        exp_at(1, "mid_s0", pk(3'd2, 3'd2, 3'd3), 3'b111, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        exp_at(1, "mid_rst", 9'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        exp_at(1, "mid_rst_idle", 9'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();

        // Base back at 0
        do_scan("post_rst", 3'd0, 3'd0, 3'd0, 3'b000, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
        // Base 1: held scan_start plus manual load_en=111 must be ignored
        do_scan("scan2", 3'd1, 3'd2, 3'd3, 3'b111, 3'd2, 3'd3, 3'd4, 1'b1, 1'b0);
        // Base 2: mode dropped mid-scan, scan still completes
        do_scan("scan3", 3'd2, 3'd3, 3'd4, 3'b111, 3'd3, 3'd4, 3'd5, 1'b0, 1'b1);
        // Base 3
        do_scan("scan4", 3'd3, 3'd4, 3'd5, 3'b111, 3'd4, 3'd5, 3'd1, 1'b0, 1'b0);
        // Base 4: lane index wraps
        do_scan("scan5", 3'd4, 3'd5, 3'd1, 3'b111, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 50 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_commut_reg_bank
`default_nettype wire
